bcd_tick_counter: RTL and testbench

- Consumes the divided clock produced by the upstream frequency divider (Divisor_Frec) as a data signal in the fast clock domain.
- Synchronises and edge-detects the divided clock, then advances a two-digit BCD counter (default 00..59) once per divided-clock rising edge.
- Provides enable, clear, parallel load, a terminal-count pulse and a load-error flag for the display/timer logic downstream.

---
 rtl/bcd_tick_counter.sv | 148 ++++++++++++++
 tb/tb_bcd_tick_counter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_tick_counter
//  Purpose  : Two-digit BCD counter (default 00..59) advanced once per rising
//             edge of a divided clock. The divided clock is treated as data:
//             it is synchronised into clk_intput and edge-detected. Enable,
//             synchronous clear, checked parallel load, a wrap pulse and a
//             rejected-load pulse are provided.
//  Ports    : clk_intput  - system clock, rising edge
//             rst_n       - asynchronous active-low reset
//             clk_div_in  - divided clock, sampled only
//             en          - 1 = count on ticks, 0 = hold
//             up_dn       - 1 = up, 0 = down (only with BCD_TICK_COUNTER_DOWN_EN)
//             clr         - synchronous clear to 00 (highest priority)
//             load        - synchronous load of load_val
//             load_val    - BCD load value, [7:4] tens, [3:0] units
//             units/tens  - registered BCD digits
//             tc_pulse    - one-cycle pulse following a wrap
//             load_err    - one-cycle pulse following a rejected load
//             running     - en delayed one cycle
//  Macro    : BCD_TICK_COUNTER_DOWN_EN adds the up_dn port and down counting.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_tick_counter #(
    parameter int UNITS_MAX   = 9,
    parameter int TENS_MAX    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_intput,
    input  logic       rst_n,
    input  logic       clk_div_in,
    input  logic       en,
`ifdef BCD_TICK_COUNTER_DOWN_EN
    input  logic       up_dn,
`endif
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       tc_pulse,
    output logic       load_err,
    output logic       running
);

    localparam logic [3:0] c_units_max = 4'(UNITS_MAX);
    localparam logic [3:0] c_tens_max  = 4'(TENS_MAX);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [3:0]             units_q, units_d;
    logic [3:0]             tens_q, tens_d;
    logic                   tc_pulse_q, tc_pulse_d;
    logic                   load_err_q, load_err_d;
    logic                   running_q, running_d;

    logic w_tick;
    logic w_load_ok;
    logic w_up;

    // Rising edge of the synchronised divided clock. The detector runs
    // independently of en so re-enabling never sees a stale edge.
    assign w_tick    = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign w_load_ok = (load_val[7:4] <= c_tens_max) && (load_val[3:0] <= c_units_max);

`ifdef BCD_TICK_COUNTER_DOWN_EN
    assign w_up = up_dn;
`else
    assign w_up = 1'b1;
`endif

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], clk_div_in};
        prev_d     = sync_q[SYNC_STAGES-1];
        units_d    = units_q;
        tens_d     = tens_q;
        tc_pulse_d = 1'b0;
        load_err_d = 1'b0;
        running_d  = en;

        // clr beats load beats tick; a tick lost to clr/load never wraps.
        if (clr) begin
            units_d = 4'd0;
            tens_d  = 4'd0;
        end else if (load) begin
            if (w_load_ok) begin
                units_d = load_val[3:0];
                tens_d  = load_val[7:4];
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en && w_tick) begin
            if (w_up) begin
                if (units_q < c_units_max) begin
                    units_d = units_q + 4'd1;
                end else begin
                    units_d = 4'd0;
                    if (tens_q < c_tens_max) begin
                        tens_d = tens_q + 4'd1;
                    end else begin
                        tens_d     = 4'd0;
                        tc_pulse_d = 1'b1;
                    end
                end
            end else begin
                if (units_q != 4'd0) begin
                    units_d = units_q - 4'd1;
                end else begin
                    units_d = c_units_max;
                    if (tens_q != 4'd0) begin
                        tens_d = tens_q - 4'd1;
                    end else begin
                        tens_d     = c_tens_max;
                        tc_pulse_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_intput or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            units_q    <= 4'd0;
            tens_q     <= 4'd0;
            tc_pulse_q <= 1'b0;
            load_err_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            units_q    <= units_d;
            tens_q     <= tens_d;
            tc_pulse_q <= tc_pulse_d;
            load_err_q <= load_err_d;
            running_q  <= running_d;
        end
    end

    assign units    = units_q;
    assign tens     = tens_q;
    assign tc_pulse = tc_pulse_q;
    assign load_err = load_err_q;
    assign running  = running_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_tick_counter
//  Purpose  : Self-checking bench for bcd_tick_counter. A behavioural model
//             keeps the count as a single integer modulo the full scale and
//             treats a clk_div_in rise seen at clock edge N as a count event
//             at edge N+SYNC_STAGES.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_tick_counter;

    localparam int U  = 9;
    localparam int T  = 5;
    localparam int SS = 2;
    localparam int M  = (T + 1) * (U + 1);

    logic       clk;
    logic       rst_n;
    logic       clk_div_in;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] units;
    logic [3:0] tens;
    logic       tc_pulse;
    logic       load_err;
    logic       running;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    int   m_n;
    logic m_tc, m_err, m_run;
    logic hist [0:SS];   // hist[i]: clk_div_in sampled i+1 edges ago

    bcd_tick_counter #(.UNITS_MAX(U), .TENS_MAX(T), .SYNC_STAGES(SS)) dut (
        .clk_intput (clk),
        .rst_n      (rst_n),
        .clk_div_in (clk_div_in),
        .en         (en),
`ifdef BCD_TICK_COUNTER_DOWN_EN
        .up_dn      (up_dn),
`endif
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .units      (units),
        .tens       (tens),
        .tc_pulse   (tc_pulse),
        .load_err   (load_err),
        .running    (running)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    wire logic [10:0] obs = {tens, units, tc_pulse, load_err, running};

    function automatic logic [10:0] model_vec();
        logic [3:0] t, u;
        t = 4'(m_n / (U + 1));
        u = 4'(m_n % (U + 1));
        return {t, u, m_tc, m_err, m_run};
    endfunction

    task automatic model_reset();
        m_n = 0; m_tc = 0; m_err = 0; m_run = 0;
        for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
    endtask

    // Advance one clock edge and update the model from the inputs seen there.
    task automatic step();
        logic tick, up;
        int   lt, lu;
        @(posedge clk);
        tick = hist[SS-1] && !hist[SS];
`ifdef BCD_TICK_COUNTER_DOWN_EN
        up = up_dn;
`else
        up = 1'b1;
`endif
        m_tc = 0; m_err = 0;
        lt = int'(load_val[7:4]);
        lu = int'(load_val[3:0]);
        if (clr) m_n = 0;
        else if (load) begin
            if (lt <= T && lu <= U) m_n = lt * (U + 1) + lu;
            else m_err = 1;
        end else if (en && tick) begin
            if (up) begin
                if (m_n == M - 1) begin m_n = 0; m_tc = 1; end
                else m_n = m_n + 1;
            end else begin
                if (m_n == 0) begin m_n = M - 1; m_tc = 1; end
                else m_n = m_n - 1;
            end
        end
        m_run = en;
        for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = clk_div_in;
        #1;
    endtask

    // One divided-clock period: high 2 edges, low 2 edges, checking every edge.
    task automatic div_pulse(input string name, inout int tc_seen);
        for (int k = 0; k < 4; k++) begin
            clk_div_in = (k < 2);
            step();
            if (tc_pulse === 1'b1) tc_seen++;
            n_cmp++;
            if (obs !== model_vec()) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", name, obs, model_vec());
            end
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if (obs !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, 11'd0);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs, model_vec());
        end
    endtask

    task automatic test_latency();
        en = 1'b1;
        repeat (3) step();
        clk_div_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            n_cmp++;
            if (obs !== model_vec()) begin
                n_fail++;
                $display("FAIL latency_edge%0d: got %h want %h", k, obs, model_vec());
            end
        end
        // Explicit: two edges after first sample of the high level -> 01, no more.
        n_cmp++;
        if ({tens, units} !== 8'h01) begin
            n_fail++;
            $display("FAIL latency_value: got %h want 01", {tens, units});
        end
        clk_div_in = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_wrap();
        int tc_seen;
        tc_seen = 0;
        do_load(8'h58);
        n_cmp++;
        if ({tens, units} !== 8'h58) begin
            n_fail++;
            $display("FAIL wrap_load: got %h want 58", {tens, units});
        end
        en = 1'b1;
        div_pulse("wrap_tick1", tc_seen);
        n_cmp++;
        if ({tens, units} !== 8'h59) begin
            n_fail++;
            $display("FAIL wrap_59: got %h want 59", {tens, units});
        end
        div_pulse("wrap_tick2", tc_seen);
        n_cmp++;
        if ({tens, units} !== 8'h00 || tc_seen != 1) begin
            n_fail++;
            $display("FAIL wrap_00: got %h tc_count %0d want 00 tc_count 1", {tens, units}, tc_seen);
        end
    endtask

    task automatic test_priority();
        int tc_seen;
        tc_seen = 0;
        en = 1'b1;
        do_load(8'h42);
        // Rise sampled at edge N; tick acts at edge N+2 together with clr.
        clk_div_in = 1'b1;
        step(); step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_cmp++;
        if ({tens, units, tc_pulse} !== {8'h00, 1'b0} || obs !== model_vec()) begin
            n_fail++;
            $display("FAIL prio_clr: got %h want %h", obs, model_vec());
        end
        clk_div_in = 1'b0;
        repeat (2) step();
        clk_div_in = 1'b1;
        step(); step();
        load = 1'b1; load_val = 8'h15;
        step();
        load = 1'b0;
        n_cmp++;
        if ({tens, units, tc_pulse} !== {8'h15, 1'b0} || obs !== model_vec()) begin
            n_fail++;
            $display("FAIL prio_load: got %h want %h", obs, model_vec());
        end
        clk_div_in = 1'b0;
        repeat (2) step();
        en = 1'b0;
        repeat (5) div_pulse("prio_hold", tc_seen);
        n_cmp++;
        if ({tens, units} !== 8'h15) begin
            n_fail++;
            $display("FAIL prio_en0: got %h want 15", {tens, units});
        end
        en = 1'b1;
        step();
    endtask

    task automatic test_load_err();
        logic [7:0] vals [0:2];
        vals[0] = 8'h5A; vals[1] = 8'h60; vals[2] = 8'h09;
        do_load(8'h23);
        for (int k = 0; k < 3; k++) begin
            do_load(vals[k]);
            n_cmp++;
            if (obs !== model_vec()) begin
                n_fail++;
                $display("FAIL load_err_%h: got %h want %h", vals[k], obs, model_vec());
            end
            step();
            n_cmp++;
            if (load_err !== 1'b0 || obs !== model_vec()) begin
                n_fail++;
                $display("FAIL load_err_clear_%h: got %h want %h", vals[k], obs, model_vec());
            end
        end
    endtask

    task automatic test_reset_midcount();
        en = 1'b1;
        do_load(8'h37);
        #4;                     // between edges
        rst_n = 1'b0;
        #3;
        model_reset();
        n_cmp++;
        if (obs !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", obs, 11'd0);
        end
        #4;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (obs !== model_vec() || {tens, units} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", obs, model_vec());
        end
        begin
            int tc_seen;
            tc_seen = 0;
            div_pulse("reset_first_tick", tc_seen);
        end
        n_cmp++;
        if ({tens, units} !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_restart: got %h want 01", {tens, units});
        end
    endtask

`ifdef BCD_TICK_COUNTER_DOWN_EN
    task automatic test_down();
        int tc_seen;
        tc_seen = 0;
        en = 1'b1;
        do_load(8'h00);
        up_dn = 1'b0;
        div_pulse("down_tick1", tc_seen);
        n_cmp++;
        if ({tens, units} !== 8'h59 || tc_seen != 1) begin
            n_fail++;
            $display("FAIL down_wrap: got %h tc_count %0d want 59 tc_count 1", {tens, units}, tc_seen);
        end
        div_pulse("down_tick2", tc_seen);
        n_cmp++;
        if ({tens, units} !== 8'h58) begin
            n_fail++;
            $display("FAIL down_58: got %h want 58", {tens, units});
        end
        up_dn = 1'b1;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            en         = ($urandom_range(0, 9) != 0);
            clr        = ($urandom_range(0, 39) == 0);
            load       = ($urandom_range(0, 24) == 0);
            load_val   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) clk_div_in = ~clk_div_in;
`ifdef BCD_TICK_COUNTER_DOWN_EN
            up_dn      = ($urandom_range(0, 3) != 0);
`endif
            step();
            n_cmp++;
            if (obs !== model_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h want %h", k, obs, model_vec());
            end
        end
        clr = 1'b0; load = 1'b0; clk_div_in = 1'b0; up_dn = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        clk_div_in = 1'b0;
        en         = 1'b0;
        up_dn      = 1'b1;
        clr        = 1'b0;
        load       = 1'b0;
        load_val   = 8'h00;
        model_reset();

        test_reset();
        test_latency();
        test_wrap();
        test_priority();
        test_load_err();
        test_reset_midcount();
`ifdef BCD_TICK_COUNTER_DOWN_EN
        test_down();
`endif
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
